// File: rtl/axi_slave_ram.sv
// axi_slave_ram: AXI-style word RAM slave with independent write and read burst engines.
module axi_slave_ram #(
  parameter int S_ID   = 4,
  parameter int MEM_AW = 10
) (
  input  logic            BUS_CLK,
  input  logic            BUS_RST,
  input  logic [S_ID-1:0] SLAVE_WR_ADDR_ID,
  input  logic [31:0]     SLAVE_WR_ADDR,
  input  logic [7:0]      SLAVE_WR_ADDR_LEN,
  input  logic [1:0]      SLAVE_WR_ADDR_BURST,
  input  logic            SLAVE_WR_ADDR_VALID,
  output logic            SLAVE_WR_ADDR_READY,
  input  logic [31:0]     SLAVE_WR_DATA,
  input  logic [3:0]      SLAVE_WR_STRB,
  input  logic            SLAVE_WR_DATA_LAST,
  input  logic            SLAVE_WR_DATA_VALID,
  output logic            SLAVE_WR_DATA_READY,
  output logic [S_ID-1:0] SLAVE_WR_BACK_ID,
  output logic [1:0]      SLAVE_WR_BACK_RESP,
  output logic            SLAVE_WR_BACK_VALID,
  input  logic            SLAVE_WR_BACK_READY,
  input  logic [S_ID-1:0] SLAVE_RD_ADDR_ID,
  input  logic [31:0]     SLAVE_RD_ADDR,
  input  logic [7:0]      SLAVE_RD_ADDR_LEN,
  input  logic [1:0]      SLAVE_RD_ADDR_BURST,
  input  logic            SLAVE_RD_ADDR_VALID,
  output logic            SLAVE_RD_ADDR_READY,
  output logic [S_ID-1:0] SLAVE_RD_BACK_ID,
  output logic [31:0]     SLAVE_RD_DATA,
  output logic [1:0]      SLAVE_RD_DATA_RESP,
  output logic            SLAVE_RD_DATA_LAST,
  output logic            SLAVE_RD_DATA_VALID,
  input  logic            SLAVE_RD_DATA_READY
);
  localparam int DEPTH = 1 << MEM_AW;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  logic [31:0] mem [DEPTH];
  w_state_e w_state_q, w_state_d;
  logic aw_ready_q, aw_ready_d;
  logic [S_ID-1:0] wid_q, wid_d;
  logic [30:0] widx_q, widx_d;
  logic [7:0] wlen_q, wlen_d;
  logic [1:0] wburst_q, wburst_d;
  logic [8:0] wcnt_q, wcnt_d;
  logic werr_q, werr_d;
  logic w_hs, w_ok, mem_we;
  r_state_e r_state_q, r_state_d;
  logic ar_ready_q, ar_ready_d;
  logic [S_ID-1:0] rid_q, rid_d;
  logic [30:0] ridx_q, ridx_d, f_idx;
  logic [7:0] rlen_q, rlen_d, rcnt_q, rcnt_d, f_len, f_cnt;
  logic [1:0] rburst_q, rburst_d, f_burst, rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic rlast_q, rlast_d;
  logic ar_hs, r_hs, r_load, f_ok;
  logic unused;
  assign unused = ^{SLAVE_WR_ADDR[1:0], SLAVE_RD_ADDR[1:0]};
  // Word index keeps one bit above the 30-bit address word so INCR never wraps.
  always_comb begin
    w_hs = w_state_q == W_DATA && SLAVE_WR_DATA_VALID;
    w_ok = !wburst_q[1] && widx_q[30:MEM_AW] == '0 && wcnt_q <= {1'b0, wlen_q};
    mem_we = w_hs && w_ok && !BUS_RST;
    w_state_d = w_state_q;
    wid_d = wid_q;
    widx_d = widx_q;
    wlen_d = wlen_q;
    wburst_d = wburst_q;
    wcnt_d = wcnt_q;
    werr_d = werr_q;
    case (w_state_q)
      W_IDLE: if (aw_ready_q && SLAVE_WR_ADDR_VALID) begin
        w_state_d = W_DATA;
        wid_d = SLAVE_WR_ADDR_ID;
        widx_d = {1'b0, SLAVE_WR_ADDR[31:2]};
        wlen_d = SLAVE_WR_ADDR_LEN;
        wburst_d = SLAVE_WR_ADDR_BURST;
        wcnt_d = '0;
        werr_d = 1'b0;
      end
      W_DATA: if (w_hs) begin
        werr_d = werr_q || !w_ok || (SLAVE_WR_DATA_LAST && wcnt_q < {1'b0, wlen_q});
        widx_d = widx_q + {30'd0, wburst_q == 2'b01};
        wcnt_d = wcnt_q + {8'd0, !wcnt_q[8]};
        w_state_d = SLAVE_WR_DATA_LAST ? W_RESP : W_DATA;
      end
      W_RESP: w_state_d = SLAVE_WR_BACK_READY ? W_IDLE : W_RESP;
      default: w_state_d = W_IDLE;
    endcase
    aw_ready_d = w_state_d == W_IDLE;
  end
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      w_state_q <= W_IDLE;
      aw_ready_q <= 1'b0;
      wid_q <= '0;
      widx_q <= '0;
      wlen_q <= '0;
      wburst_q <= '0;
      wcnt_q <= '0;
      werr_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      aw_ready_q <= aw_ready_d;
      wid_q <= wid_d;
      widx_q <= widx_d;
      wlen_q <= wlen_d;
      wburst_q <= wburst_d;
      wcnt_q <= wcnt_d;
      werr_q <= werr_d;
    end
  end
  always_ff @(posedge BUS_CLK) begin
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (SLAVE_WR_STRB[b]) mem[widx_q[MEM_AW-1:0]][8*b +: 8] <= SLAVE_WR_DATA[8*b +: 8];
  end
  // The output register is refilled from the next word on every accepted beat.
  always_comb begin
    ar_hs = ar_ready_q && SLAVE_RD_ADDR_VALID;
    r_hs = r_state_q == R_DATA && SLAVE_RD_DATA_READY;
    r_load = ar_hs || (r_hs && !rlast_q);
    f_idx = ar_hs ? {1'b0, SLAVE_RD_ADDR[31:2]} : ridx_q + {30'd0, rburst_q == 2'b01};
    f_burst = ar_hs ? SLAVE_RD_ADDR_BURST : rburst_q;
    f_len = ar_hs ? SLAVE_RD_ADDR_LEN : rlen_q;
    f_cnt = ar_hs ? 8'd0 : rcnt_q + 8'd1;
    f_ok = !f_burst[1] && f_idx[30:MEM_AW] == '0;
    ridx_d = r_load ? f_idx : ridx_q;
    rburst_d = r_load ? f_burst : rburst_q;
    rlen_d = r_load ? f_len : rlen_q;
    rcnt_d = r_load ? f_cnt : rcnt_q;
    rdata_d = r_load ? (f_ok ? mem[f_idx[MEM_AW-1:0]] : 32'd0) : rdata_q;
    rresp_d = r_load ? (f_ok ? 2'b00 : 2'b10) : rresp_q;
    rlast_d = r_load ? f_cnt == f_len : (r_hs ? 1'b0 : rlast_q);
    rid_d = ar_hs ? SLAVE_RD_ADDR_ID : rid_q;
    r_state_d = ar_hs ? R_DATA : (r_hs && rlast_q) ? R_IDLE : r_state_q;
    ar_ready_d = r_state_d == R_IDLE;
  end
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      r_state_q <= R_IDLE;
      ar_ready_q <= 1'b0;
      rid_q <= '0;
      ridx_q <= '0;
      rlen_q <= '0;
      rburst_q <= '0;
      rcnt_q <= '0;
      rdata_q <= '0;
      rresp_q <= '0;
      rlast_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      ar_ready_q <= ar_ready_d;
      rid_q <= rid_d;
      ridx_q <= ridx_d;
      rlen_q <= rlen_d;
      rburst_q <= rburst_d;
      rcnt_q <= rcnt_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      rlast_q <= rlast_d;
    end
  end
  assign SLAVE_WR_ADDR_READY = aw_ready_q;
  assign SLAVE_WR_DATA_READY = w_state_q == W_DATA;
  assign SLAVE_WR_BACK_ID = wid_q;
  assign SLAVE_WR_BACK_RESP = {werr_q, 1'b0};
  assign SLAVE_WR_BACK_VALID = w_state_q == W_RESP;
  assign SLAVE_RD_ADDR_READY = ar_ready_q;
  assign SLAVE_RD_BACK_ID = rid_q;
  assign SLAVE_RD_DATA = rdata_q;
  assign SLAVE_RD_DATA_RESP = rresp_q;
  assign SLAVE_RD_DATA_LAST = rlast_q;
  assign SLAVE_RD_DATA_VALID = r_state_q == R_DATA;
endmodule

// File: tb/tb_axi_slave_ram.sv
// tb_axi_slave_ram: directed table plus randomized bursts checked against a word-array memory model.
module tb_axi_slave_ram;
  localparam int DEPTH = 1024;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [3:0] aw_id = 0, b_id, ar_id = 0, r_id;
  logic [31:0] aw_addr = 0, w_data = 0, ar_addr = 0, r_data;
  logic [7:0] aw_len = 0, ar_len = 0;
  logic [1:0] aw_burst = 0, ar_burst = 0, b_resp, r_resp;
  logic [3:0] w_strb = 0;
  logic aw_valid = 0, aw_ready, w_last = 0, w_valid = 0, w_ready, b_valid, b_ready = 0;
  logic ar_valid = 0, ar_ready, r_last, r_valid, r_ready = 0;
  int n_chk = 0, n_fail = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] wdat [300];
  logic [3:0] wstb [300];

  axi_slave_ram #(.S_ID(4), .MEM_AW(10)) dut (
    .BUS_CLK(clk), .BUS_RST(rst),
    .SLAVE_WR_ADDR_ID(aw_id), .SLAVE_WR_ADDR(aw_addr), .SLAVE_WR_ADDR_LEN(aw_len),
    .SLAVE_WR_ADDR_BURST(aw_burst), .SLAVE_WR_ADDR_VALID(aw_valid), .SLAVE_WR_ADDR_READY(aw_ready),
    .SLAVE_WR_DATA(w_data), .SLAVE_WR_STRB(w_strb), .SLAVE_WR_DATA_LAST(w_last),
    .SLAVE_WR_DATA_VALID(w_valid), .SLAVE_WR_DATA_READY(w_ready),
    .SLAVE_WR_BACK_ID(b_id), .SLAVE_WR_BACK_RESP(b_resp), .SLAVE_WR_BACK_VALID(b_valid),
    .SLAVE_WR_BACK_READY(b_ready),
    .SLAVE_RD_ADDR_ID(ar_id), .SLAVE_RD_ADDR(ar_addr), .SLAVE_RD_ADDR_LEN(ar_len),
    .SLAVE_RD_ADDR_BURST(ar_burst), .SLAVE_RD_ADDR_VALID(ar_valid), .SLAVE_RD_ADDR_READY(ar_ready),
    .SLAVE_RD_BACK_ID(r_id), .SLAVE_RD_DATA(r_data), .SLAVE_RD_DATA_RESP(r_resp),
    .SLAVE_RD_DATA_LAST(r_last), .SLAVE_RD_DATA_VALID(r_valid), .SLAVE_RD_DATA_READY(r_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Spec-level write effect: beats 0..min(nb-1,len) land if the burst type is legal and in range.
  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [7:0] len,
                                             input logic [1:0] burst, input int nb);
    logic err;
    int idx;
    err = burst[1] || nb != int'(len) + 1;
    for (int b = 0; b < nb && b <= int'(len); b++) begin
      idx = int'(addr >> 2) + ((burst == 2'b01) ? b : 0);
      if (idx >= DEPTH) err = 1'b1;
      else if (!burst[1])
        for (int i = 0; i < 4; i++) if (wstb[b][i]) model[idx][8*i +: 8] = wdat[b][8*i +: 8];
    end
    return err ? 2'b10 : 2'b00;
  endfunction

  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    aw_id = id; aw_addr = addr; aw_len = len; aw_burst = burst; aw_valid = 1;
    for (int k = 0; k < 50 && !aw_ready; k++) tick();
    chk("aw_ready", aw_ready, 1);
    tick();
    aw_valid = 0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
    w_data = d; w_strb = s; w_last = l; w_valid = 1;
    for (int k = 0; k < 50 && !w_ready; k++) tick();
    chk("w_ready", w_ready, 1);
    tick();
    w_valid = 0; w_last = 0;
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    ar_id = id; ar_addr = addr; ar_len = len; ar_burst = burst; ar_valid = 1;
    for (int k = 0; k < 50 && !ar_ready; k++) tick();
    chk("ar_ready", ar_ready, 1);
    tick();
    ar_valid = 0;
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input int nb, output logic [1:0] resp);
    logic [1:0] exp;
    aw_send(id, addr, len, burst);
    for (int b = 0; b < nb; b++) w_beat(wdat[b], wstb[b], b == nb - 1);
    chk("bvalid_next", b_valid, 1);
    chk("bid", b_id, id);
    resp = b_resp;
    repeat (2) begin
      tick();
      chk("bvalid_hold", b_valid, 1);
      chk("bresp_hold", b_resp, resp);
      chk("bid_hold", b_id, id);
    end
    b_ready = 1;
    tick();
    b_ready = 0;
    chk("bvalid_drop", b_valid, 0);
    chk("aw_ready_back", aw_ready, 1);
    exp = model_write(addr, len, burst, nb);
    chk("bresp", resp, exp);
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int mode,
                            output logic [31:0] fd, output logic [1:0] fr);
    int beat = 0, idx;
    logic ok, acc;
    fd = 0; fr = 0;
    ar_send(id, addr, len, burst);
    chk("rvalid_first", r_valid, 1);
    for (int cyc = 0; beat <= int'(len) && cyc < 400; cyc++) begin
      r_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : 1'($urandom % 2);
      idx = int'(addr >> 2) + ((burst == 2'b01) ? beat : 0);
      ok = !burst[1] && idx < DEPTH;
      chk("rvalid", r_valid, 1);
      chk("rdata", r_data, ok ? model[idx] : 32'd0);
      chk("rresp", r_resp, ok ? 2'b00 : 2'b10);
      chk("rlast", r_last, beat == int'(len));
      chk("rid", r_id, id);
      if (beat == 0) begin fd = r_data; fr = r_resp; end
      acc = r_ready && r_valid;
      tick();
      if (acc) beat++;
    end
    r_ready = 0;
    chk("r_beats", beat, int'(len) + 1);
    chk("rvalid_end", r_valid, 0);
  endtask

  typedef struct {
    bit rd; logic [3:0] id; logic [31:0] addr; logic [7:0] len; logic [1:0] burst; int nb;
    logic [3:0] strb; logic [31:0] dbase; logic [1:0] resp; logic [31:0] first; bit chk1; int mode;
  } vec_t;

  initial begin
    vec_t tv[$];
    logic [1:0] resp, r2;
    logic [31:0] fd, addr;
    logic [7:0] len;
    logic [1:0] burst;
    int nb, sel;
    tv.push_back('{0, 3, 32'h10, 3, 2'b01, 4, 4'hF, 32'd1, 2'b00, 0, 0, 0});
    tv.push_back('{1, 5, 32'h10, 3, 2'b01, 0, 0, 0, 2'b00, 32'd1, 1, 0});
    tv.push_back('{0, 1, 32'h40, 0, 2'b01, 1, 4'hF, 32'hAABBCCDD, 2'b00, 0, 0, 0});
    tv.push_back('{0, 2, 32'h40, 0, 2'b01, 1, 4'h5, 32'h11223344, 2'b00, 0, 0, 0});
    tv.push_back('{1, 6, 32'h40, 0, 2'b01, 0, 0, 0, 2'b00, 32'hAA22CC44, 1, 0});
    tv.push_back('{0, 4, 32'h100, 7, 2'b01, 8, 4'hF, 32'h100, 2'b00, 0, 0, 0});
    tv.push_back('{1, 7, 32'h100, 7, 2'b01, 0, 0, 0, 2'b00, 32'h100, 1, 1});
    tv.push_back('{0, 8, 32'hFF8, 3, 2'b01, 4, 4'hF, 32'h5000, 2'b10, 0, 0, 0});
    tv.push_back('{1, 9, 32'hFF8, 3, 2'b01, 0, 0, 0, 2'b00, 32'h5000, 1, 0});
    tv.push_back('{0, 10, 32'h200, 3, 2'b01, 3, 4'hF, 32'h600, 2'b10, 0, 0, 0});
    tv.push_back('{1, 11, 32'h200, 1, 2'b10, 0, 0, 0, 2'b10, 32'd0, 1, 0});
    tv.push_back('{0, 12, 32'h300, 3, 2'b00, 4, 4'hF, 32'h700, 2'b00, 0, 0, 0});
    tv.push_back('{1, 13, 32'h300, 0, 2'b01, 0, 0, 0, 2'b00, 32'h703, 1, 2});
    tv.push_back('{0, 14, 32'h400, 1, 2'b11, 2, 4'hF, 32'h900, 2'b10, 0, 0, 0});
    tv.push_back('{0, 15, 32'h500, 1, 2'b01, 3, 4'hF, 32'hA00, 2'b10, 0, 0, 0});
    tv.push_back('{1, 1, 32'h500, 2, 2'b01, 0, 0, 0, 2'b00, 32'hA00, 1, 0});
    // Reset state
    repeat (3) tick();
    chk("rst_aw_ready", aw_ready, 0);
    chk("rst_ar_ready", ar_ready, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_bvalid", b_valid, 0);
    chk("rst_rvalid", r_valid, 0);
    chk("rst_rlast", r_last, 0);
    chk("rst_rdata", r_data, 0);
    chk("rst_ids", {b_id, r_id}, 0);
    chk("rst_resps", {b_resp, r_resp}, 0);
    rst = 0;
    tick();
    chk("rel_aw_ready", aw_ready, 1);
    chk("rel_ar_ready", ar_ready, 1);
    // Fill the whole memory so every later read has a defined expectation
    for (int blk = 0; blk < 4; blk++) begin
      for (int b = 0; b < 256; b++) begin wdat[b] = $urandom; wstb[b] = 4'hF; end
      write_burst(4'(blk), 32'(blk * 1024), 8'd255, 2'b01, 256, resp);
      chk("fill_bresp", resp, 2'b00);
    end
    foreach (tv[i]) begin
      if (!tv[i].rd) begin
        for (int b = 0; b < tv[i].nb; b++) begin wdat[b] = tv[i].dbase + 32'(b); wstb[b] = tv[i].strb; end
        write_burst(tv[i].id, tv[i].addr, tv[i].len, tv[i].burst, tv[i].nb, resp);
        chk("tv_bresp", resp, tv[i].resp);
      end else begin
        read_burst(tv[i].id, tv[i].addr, tv[i].len, tv[i].burst, tv[i].mode, fd, resp);
        if (tv[i].chk1) begin
          chk("tv_rdata0", fd, tv[i].first);
          chk("tv_rresp0", resp, tv[i].resp);
        end
      end
    end
    // Concurrent write and read of disjoint regions
    for (int b = 0; b < 4; b++) begin wdat[b] = $urandom; wstb[b] = 4'hF; end
    fork
      write_burst(4'd4, 32'h600, 8'd3, 2'b01, 4, resp);
      read_burst(4'd5, 32'h20, 8'd7, 2'b01, 0, fd, r2);
    join
    read_burst(4'd6, 32'h600, 8'd3, 2'b01, 0, fd, r2);
    // Randomized bursts
    for (int n = 0; n < 40; n++) begin
      sel = $urandom % 8;
      addr = sel == 0 ? 32'h1000 + 4 * ($urandom % 64) : sel == 1 ? 32'hFF0 + 4 * ($urandom % 4)
           : 4 * $urandom_range(0, 1023);
      addr = addr | 32'($urandom % 4);
      len = 8'($urandom % 8);
      sel = $urandom % 8;
      burst = sel == 0 ? 2'(2 + $urandom % 2) : sel == 1 ? 2'b00 : 2'b01;
      if ($urandom % 2 == 0) begin
        sel = $urandom % 8;
        nb = sel == 0 ? int'(len) + 2 : (sel == 1 && len > 0) ? int'(len) : int'(len) + 1;
        for (int b = 0; b < nb; b++) begin wdat[b] = $urandom; wstb[b] = 4'($urandom); end
        write_burst(4'($urandom), addr, len, burst, nb, resp);
      end else read_burst(4'($urandom), addr, len, burst, $urandom % 3, fd, r2);
    end
    // Reset in the middle of a write (beat 2 pending) and a stalled read
    for (int b = 0; b < 4; b++) begin wdat[b] = 32'hC0DE0000 + 32'(b); wstb[b] = 4'hF; end
    aw_send(4'd2, 32'h900, 8'd3, 2'b01);
    w_beat(wdat[0], 4'hF, 0);
    w_beat(wdat[1], 4'hF, 0);
    resp = model_write(32'h900, 8'd3, 2'b01, 2);
    ar_send(4'd3, 32'h800, 8'd7, 2'b01);
    w_data = wdat[2]; w_strb = 4'hF; w_valid = 1; rst = 1;
    tick();
    w_valid = 0;
    chk("mid_rst_aw_ready", aw_ready, 0);
    chk("mid_rst_ar_ready", ar_ready, 0);
    chk("mid_rst_bvalid", b_valid, 0);
    chk("mid_rst_rvalid", r_valid, 0);
    chk("mid_rst_rlast", r_last, 0);
    chk("mid_rst_rdata", r_data, 0);
    tick();
    rst = 0;
    tick();
    chk("post_rst_aw_ready", aw_ready, 1);
    chk("post_rst_ar_ready", ar_ready, 1);
    chk("post_rst_bvalid", b_valid, 0);
    chk("post_rst_rvalid", r_valid, 0);
    read_burst(4'd7, 32'h800, 8'd7, 2'b01, 0, fd, r2);
    read_burst(4'd8, 32'h900, 8'd3, 2'b01, 2, fd, r2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/axi_slave_ram.md
AXI_SLAVE_RAM -- requirements
Module: axi_slave_ram

Interface
REQ-001 S_ID, default 4, SHALL set ID width and equal interconnect M_WIDTH+M_ID.
REQ-002 MEM_AW, default 10, SHALL set log2 of memory depth in 32-bit words.
REQ-003 BUS_CLK  in  1  SHALL be the single clock; all logic on its rising edge.
REQ-004 BUS_RST  in  1  SHALL be a synchronous, active-high reset.
REQ-005 SLAVE_WR_ADDR_ID  in  S_ID  write burst ID.
REQ-006 SLAVE_WR_ADDR  in  32  byte address, already translated to local offset.
REQ-007 SLAVE_WR_ADDR_LEN  in  8  beats minus one.
REQ-008 SLAVE_WR_ADDR_BURST  in  2  00 FIXED, 01 INCR, 10/11 unsupported.
REQ-009 SLAVE_WR_ADDR_VALID  in  1  write address valid.
REQ-010 SLAVE_WR_ADDR_READY  out  1  write address ready.
REQ-011 SLAVE_WR_DATA  in  32  write data.
REQ-012 SLAVE_WR_STRB  in  4  byte enables; bit i gates DATA[8i+7:8i].
REQ-013 SLAVE_WR_DATA_LAST  in  1  last write beat.
REQ-014 SLAVE_WR_DATA_VALID  in  1  write data valid.
REQ-015 SLAVE_WR_DATA_READY  out  1  write data ready.
REQ-016 SLAVE_WR_BACK_ID  out  S_ID  response ID.
REQ-017 SLAVE_WR_BACK_RESP  out  2  00 OKAY, 10 SLVERR.
REQ-018 SLAVE_WR_BACK_VALID  out  1  write response valid.
REQ-019 SLAVE_WR_BACK_READY  in  1  write response ready.
REQ-020 SLAVE_RD_ADDR_ID  in  S_ID  read burst ID.
REQ-021 SLAVE_RD_ADDR  in  32  byte address, local offset.
REQ-022 SLAVE_RD_ADDR_LEN  in  8  beats minus one.
REQ-023 SLAVE_RD_ADDR_BURST  in  2  as REQ-008.
REQ-024 SLAVE_RD_ADDR_VALID  in  1  read address valid.
REQ-025 SLAVE_RD_ADDR_READY  out  1  read address ready.
REQ-026 SLAVE_RD_BACK_ID  out  S_ID  read data ID.
REQ-027 SLAVE_RD_DATA  out  32  read data.
REQ-028 SLAVE_RD_DATA_RESP  out  2  per-beat response, 00 OKAY, 10 SLVERR.
REQ-029 SLAVE_RD_DATA_LAST  out  1  last read beat.
REQ-030 SLAVE_RD_DATA_VALID  out  1  read data valid.
REQ-031 SLAVE_RD_DATA_READY  in  1  read data ready.

Function
REQ-032 Write and read channels SHALL run as independent FSMs, concurrently, one burst each outstanding.
REQ-033 Write FSM SHALL be W_IDLE (ADDR_READY=1) -> W_DATA on AW handshake (capture ID/addr/len/burst, beat count 0) -> W_RESP on handshake with DATA_LAST=1 -> W_IDLE on BACK handshake.
REQ-034 In W_DATA, DATA_READY SHALL be 1 and each handshake SHALL write enabled bytes at word ADDR[MEM_AW+1:2]; INCR advances word index by 1 per beat, FIXED holds.
REQ-035 Beats beyond LEN+1, beats with word index >= 2**MEM_AW, and unsupported burst types SHALL not write memory and SHALL set RESP=SLVERR; LAST before beat LEN SHALL also give SLVERR.
REQ-036 BACK_VALID SHALL assert the cycle after the LAST handshake and hold ID/RESP stable until BACK_READY; W_IDLE ADDR_READY reasserts the following cycle.
REQ-037 Read FSM SHALL be R_IDLE (ADDR_READY=1) -> R_DATA on AR handshake -> R_IDLE on handshake of beat LEN; first RD_DATA_VALID asserts exactly 1 cycle after AR handshake.
REQ-038 With DATA_READY held 1, read SHALL sustain one beat per cycle via prefetch of the next word; DATA/RESP/LAST/ID SHALL hold while VALID=1 and READY=0.
REQ-039 RD_DATA_LAST SHALL be 1 only on beat LEN; out-of-range beats and unsupported bursts SHALL return DATA=0, RESP=SLVERR, still LEN+1 beats.
REQ-040 Same-cycle write and read fetch of one word SHALL return the pre-write value.
REQ-041 No address wraps: INCR word index past 2**MEM_AW-1 is out of range, not modulo.

Reset
REQ-042 BUS_RST SHALL force both FSMs to idle, all VALID/LAST outputs 0, both ADDR_READY 0 during reset then 1 the cycle after release, DATA_READY 0, IDs/RESP/RD_DATA 0; memory contents SHALL not be cleared; in-flight bursts are abandoned with no response.

Verification
REQ-043 Write INCR addr 0x10, LEN=3, data 1..4, STRB=F -> BACK RESP=00, ID echoed; read back LEN=3 -> 1,2,3,4, LAST on 4th, RESP=00.
REQ-044 Write 0xAABBCCDD then 0x11223344 STRB=0101 same word -> read returns 0xAA22CC44.
REQ-045 Read LEN=7 with READY toggling 1,0 each cycle -> 8 beats, data stable across stalls, VALID first 1 cycle after AR handshake.
REQ-046 MEM_AW=10, write INCR addr 0xFF8, LEN=3 -> words 1022,1023 written, RESP=10; read same -> beats 3,4 DATA=0 RESP=10.
REQ-047 Write LEN=3 with LAST on beat 2 -> RESP=10; BURST=10 read LEN=1 -> two beats DATA=0 RESP=10.
REQ-048 Assert BUS_RST mid-write (beat 2) and mid-read -> no BACK/RD VALID, both ADDR_READY=1 one cycle after release, prior committed data intact.
